branch_resolve_ctrl: RTL
========================

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
- REQ-001: Parameter STAT_W, default 16: width of the statistics counters.
- REQ-002: i_clk  input  1  sole clock; all state updates on the rising edge.
- REQ-003: i_reset  input  1  reset; synchronous, active-high.
- REQ-004: i_valid  input  1  upstream branch request valid.
- REQ-005: o_ready  output  1  block can accept a request.
- REQ-006: i_funct3  input  3  RISC-V branch funct3.
- REQ-007: i_rs1_data, i_rs2_data  input  32 each  compare operands.
- REQ-008: i_pc, i_imm  input  32 each  branch PC and sign-extended B-immediate.
- REQ-009: i_pred_taken  input  1  front-end prediction for this branch.
- REQ-010: i_flush  input  1  kill any in-flight request.
- REQ-011: o_valid  output  1  result valid.
- REQ-012: i_ready  input  1  downstream accepts the result.
- REQ-013: o_taken, o_mispredict, o_illegal, o_misalign  output  1 each  resolution flags.
- REQ-014: o_target  output  32  next PC.
- REQ-015: o_br_count, o_mp_count  output  STAT_W each  statistics; present only with BRC_STATS_EN.

Function
- REQ-016: The block SHALL contain one brc instance fed from registered operands; i_br_un SHALL equal the registered funct3[1].
- REQ-017: FSM states IDLE, EVAL and RESP; o_ready = 1 only in IDLE.
- REQ-018: IDLE -> EVAL on i_valid & o_ready; funct3, operands, pc, imm and pred SHALL be captured on that edge.
- REQ-019: EVAL -> RESP unconditionally after one cycle; all result registers SHALL be loaded on that edge.
- REQ-020: RESP: o_valid = 1, outputs stable; RESP -> IDLE on i_ready, otherwise hold.
- REQ-021: Latency: o_valid asserts exactly 2 cycles after the accept edge; minimum initiation interval 3 cycles.
- REQ-022: Taken decode: 000 equal; 001 not equal; 100/110 less; 101/111 not less (less taken from brc).
- REQ-023: funct3 010/011: o_illegal = 1, o_taken = 0, target = pc+4.
- REQ-024: o_target = taken ? pc+imm : pc+4, modulo 2^32; wrap-around SHALL be silent.
- REQ-025: o_misalign = o_taken & (o_target[1:0] != 0).
- REQ-026: o_mispredict = o_taken XOR pred; forced to 0 when o_illegal.
- REQ-027: i_flush in any state SHALL force IDLE on the next edge and drop o_valid; a flush SHALL take priority over a simultaneous accept or i_ready; the flushed request produces no result.
- REQ-028: Result flags and o_target SHALL be 0 whenever o_valid = 0.

Reset
- REQ-029: i_reset is sampled on i_clk only; when asserted, the FSM SHALL go to IDLE and all result registers and counters SHALL clear to 0.
- REQ-030: After reset, o_ready = 1 and o_valid = 0; reset SHALL take priority over i_flush and i_valid.
- REQ-031: Reset asserted mid-operation (EVAL or RESP) SHALL discard the request with no result.

Configuration
- REQ-032: Macro BRC_STATS_EN defined: o_br_count SHALL increment on every RESP->IDLE handshake, and o_mp_count SHALL additionally increment when o_mispredict = 1.
- REQ-033: Both counters SHALL saturate at all-ones; flushed requests SHALL not count.
- REQ-034: Macro BRC_STATS_EN undefined: the counters and their ports SHALL be absent; all other behaviour SHALL be identical.

Verification
- REQ-035: BEQ, rs1=rs2=0x5, pc=0x100, imm=0x20, pred=0 -> o_valid 2 cycles after accept, taken=1, target=0x120, mispredict=1.
- REQ-036: BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1; BLTU with the same operands -> taken=0, target=pc+4.
- REQ-037: funct3=010 -> illegal=1, taken=0, mispredict=0; pc=0xFFFFFFFC, not taken -> target=0x00000000.
- REQ-038: Hold i_ready=0 for 5 cycles in RESP -> outputs stable and o_ready=0; i_flush in EVAL -> no o_valid, IDLE next cycle.
- REQ-039: BRC_STATS_EN, STAT_W=2: 5 mispredicted branches -> o_br_count=3 and o_mp_count=3 (saturated); i_reset in RESP -> counters 0, o_valid 0 next cycle.

Source files
------------

// File: rtl/branch_resolve_ctrl_if.sv
// Request/response bundle for branch_resolve_ctrl: operand request in, resolution result out.
interface branch_resolve_ctrl_if;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [31:0] i_pc;
  logic [31:0] i_imm;
  logic        i_pred_taken;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic        o_taken;
  logic        o_mispredict;
  logic        o_illegal;
  logic        o_misalign;
  logic [31:0] o_target;

  modport slave (
    input  i_valid, i_funct3, i_rs1_data, i_rs2_data, i_pc, i_imm, i_pred_taken,
    input  i_flush, i_ready,
    output o_ready, o_valid, o_taken, o_mispredict, o_illegal, o_misalign, o_target
  );

  modport master (
    output i_valid, i_funct3, i_rs1_data, i_rs2_data, i_pc, i_imm, i_pred_taken,
    output i_flush, i_ready,
    input  o_ready, o_valid, o_taken, o_mispredict, o_illegal, o_misalign, o_target
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution unit: registered operands -> brc compare -> registered result (IDLE/EVAL/RESP).
// Optional statistics counters are built only when BRC_STATS_EN is defined.

// Equality / less-than comparator for RISC-V branches.
module brc (
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic        i_br_un,
  output logic        o_eq,
  output logic        o_lt
);
  // Signed or unsigned compare selected by i_br_un.
  always_comb begin
    o_eq = (i_rs1 == i_rs2);
    if (i_br_un) begin
      o_lt = (i_rs1 < i_rs2);
    end else begin
      o_lt = ($signed(i_rs1) < $signed(i_rs2));
    end
  end
endmodule

module branch_resolve_ctrl #(
  parameter int STAT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  branch_resolve_ctrl_if.slave  bus
`ifdef BRC_STATS_EN
  ,
  output logic [STAT_W-1:0]     o_br_count,
  output logic [STAT_W-1:0]     o_mp_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d, pc_q, pc_d, imm_q, imm_d;
  logic        pred_q, pred_d;
  logic        ready_q, ready_d, valid_q, valid_d;
  logic        taken_q, taken_d, mp_q, mp_d, ill_q, ill_d, mis_q, mis_d;
  logic [31:0] target_q, target_d;
  logic        cmp_eq_s, cmp_lt_s;
  logic        eval_taken_s, eval_ill_s;
  logic [31:0] eval_target_s;

  brc u_brc (
    .i_rs1   (rs1_q),
    .i_rs2   (rs2_q),
    .i_br_un (funct3_q[1]),
    .o_eq    (cmp_eq_s),
    .o_lt    (cmp_lt_s)
  );

`ifdef BRC_STATS_EN
  localparam logic [STAT_W-1:0] CNT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] CNT_MAX = {STAT_W{1'b1}};
  logic [STAT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;
  assign o_br_count = br_cnt_q;
  assign o_mp_count = mp_cnt_q;
`endif

  // Resolve the captured branch from the comparator outputs.
  always_comb begin
    eval_taken_s = 1'b0;
    eval_ill_s   = 1'b0;
    case (funct3_q)
      3'b000:         eval_taken_s = cmp_eq_s;
      3'b001:         eval_taken_s = ~cmp_eq_s;
      3'b100, 3'b110: eval_taken_s = cmp_lt_s;
      3'b101, 3'b111: eval_taken_s = ~cmp_lt_s;
      default:        eval_ill_s   = 1'b1;
    endcase
    if (eval_taken_s) begin
      eval_target_s = pc_q + imm_q;
    end else begin
      eval_target_s = pc_q + 32'd4;
    end
  end

  // Next-state, capture and result-register logic; flush overrides every state.
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    pred_d   = pred_q;
    valid_d  = valid_q;
    taken_d  = taken_q;
    mp_d     = mp_q;
    ill_d    = ill_q;
    mis_d    = mis_q;
    target_d = target_q;
`ifdef BRC_STATS_EN
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
`endif
    if (bus.i_flush) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      taken_d  = 1'b0;
      mp_d     = 1'b0;
      ill_d    = 1'b0;
      mis_d    = 1'b0;
      target_d = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid && ready_q) begin
            state_d  = EVAL;
            funct3_d = bus.i_funct3;
            rs1_d    = bus.i_rs1_data;
            rs2_d    = bus.i_rs2_data;
            pc_d     = bus.i_pc;
            imm_d    = bus.i_imm;
            pred_d   = bus.i_pred_taken;
          end else begin
            state_d = IDLE;
          end
        end
        EVAL: begin
          state_d  = RESP;
          valid_d  = 1'b1;
          taken_d  = eval_taken_s;
          ill_d    = eval_ill_s;
          target_d = eval_target_s;
          mis_d    = eval_taken_s & (eval_target_s[1:0] != 2'b00);
          mp_d     = eval_ill_s ? 1'b0 : (eval_taken_s ^ pred_q);
        end
        RESP: begin
          if (bus.i_ready) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            taken_d  = 1'b0;
            mp_d     = 1'b0;
            ill_d    = 1'b0;
            mis_d    = 1'b0;
            target_d = 32'd0;
`ifdef BRC_STATS_EN
            if (br_cnt_q != CNT_MAX) begin
              br_cnt_d = br_cnt_q + CNT_ONE;
            end else begin
              br_cnt_d = br_cnt_q;
            end
            if (mp_q && (mp_cnt_q != CNT_MAX)) begin
              mp_cnt_d = mp_cnt_q + CNT_ONE;
            end else begin
              mp_cnt_d = mp_cnt_q;
            end
`endif
          end else begin
            state_d = RESP;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
    ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      funct3_q <= 3'd0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      pc_q     <= 32'd0;
      imm_q    <= 32'd0;
      pred_q   <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      taken_q  <= 1'b0;
      mp_q     <= 1'b0;
      ill_q    <= 1'b0;
      mis_q    <= 1'b0;
      target_q <= 32'd0;
`ifdef BRC_STATS_EN
      br_cnt_q <= {STAT_W{1'b0}};
      mp_cnt_q <= {STAT_W{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      pred_q   <= pred_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      taken_q  <= taken_d;
      mp_q     <= mp_d;
      ill_q    <= ill_d;
      mis_q    <= mis_d;
      target_q <= target_d;
`ifdef BRC_STATS_EN
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
`endif
    end
  end

  assign bus.o_ready      = ready_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_taken      = taken_q;
  assign bus.o_mispredict = mp_q;
  assign bus.o_illegal    = ill_q;
  assign bus.o_misalign   = mis_q;
  assign bus.o_target     = target_q;

endmodule
